// File: rtl/bdma_requester_pkg.sv
// Shared encodings for the byte-DMA requester: BTYPE packing modes,
// register-select codes and the transfer state machine.
package bdma_requester_pkg;

    localparam logic [1:0] BTYPE_PM24   = 2'b00;
    localparam logic [1:0] BTYPE_DM16   = 2'b01;
    localparam logic [1:0] BTYPE_DM8_HI = 2'b10;
    localparam logic [1:0] BTYPE_DM8_LO = 2'b11;

    localparam logic [1:0] SEL_BIAD    = 2'd0;
    localparam logic [1:0] SEL_BEAD    = 2'd1;
    localparam logic [1:0] SEL_BCTL    = 2'd2;
    localparam logic [1:0] SEL_BWCOUNT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BYTE  = 2'd1,
        ST_STEAL = 2'd2
    } state_e;

    function automatic logic [1:0] bytes_per_word(input logic [1:0] btype);
        case (btype)
            BTYPE_PM24: bytes_per_word = 2'd3;
            BTYPE_DM16: bytes_per_word = 2'd2;
            default:    bytes_per_word = 2'd1;
        endcase
    endfunction

endpackage

// File: rtl/bdma_requester_packer.sv
// Byte pack/unpack shift register and per-word byte counter. The current
// outgoing byte always sits in [23:16]; incoming bytes enter at [7:0].
module bdma_packer
    import bdma_requester_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  btype,
    input  logic        dir,
    input  logic        clear,
    input  logic        latch,
    input  logic        shift,
    input  logic [7:0]  byte_in,
    input  logic [23:0] word_in,
    output logic [23:0] word_out,
    output logic [7:0]  byte_out,
    output logic        last_byte
);
    logic [23:0] sreg_q, sreg_d;
    logic [1:0]  cnt_q, cnt_d;

    always_comb begin
        sreg_d = sreg_q;
        cnt_d  = cnt_q;
        if (clear) begin
            sreg_d = '0;
            cnt_d  = '0;
        end else if (latch) begin
            // Pre-align the word so its first byte to send lands in [23:16].
            cnt_d = '0;
            case (btype)
                BTYPE_PM24:                sreg_d = word_in;
                BTYPE_DM16, BTYPE_DM8_HI:  sreg_d = {word_in[15:0], 8'h00};
                default:                   sreg_d = {word_in[7:0], 16'h0000};
            endcase
        end else if (shift) begin
            sreg_d = {sreg_q[15:0], dir ? 8'h00 : byte_in};
            cnt_d  = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg_q <= '0;
            cnt_q  <= '0;
        end else begin
            sreg_q <= sreg_d;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        case (btype)
            BTYPE_DM16:   word_out = {8'h00, sreg_q[15:0]};
            BTYPE_DM8_HI: word_out = {8'h00, sreg_q[7:0], 8'h00};
            BTYPE_DM8_LO: word_out = {16'h0000, sreg_q[7:0]};
            default:      word_out = sreg_q;
        endcase
    end

    assign byte_out  = sreg_q[23:16];
    assign last_byte = (cnt_q == (bytes_per_word(btype) - 2'd1));

endmodule

// File: rtl/bdma_requester.sv
// Byte-DMA requester: moves words between 8-bit external memory and core
// PM/DM by stealing core cycles, programmed through a small register bus.
module bdma_requester
    import bdma_requester_pkg::*;
(
    input  logic        DSPCLK,
    input  logic        T_RST,
    input  logic        reg_we,
    input  logic [1:0]  reg_sel,
    input  logic [13:0] reg_wd,
    input  logic [7:0]  ext_rdata,
    input  logic        ext_ack,
    input  logic        BM_cyc,
    input  logic        BPM_cyc,
    input  logic        BDM_cyc,
    input  logic [23:0] core_rdata,
    output logic        BSreqx,
    output logic [13:0] BIAD,
    output logic [23:0] core_wdata,
    output logic        ext_req,
    output logic        ext_we,
    output logic [13:0] ext_addr,
    output logic [7:0]  ext_wdata,
    output logic        busy,
    output logic        bdma_irq,
    output logic        type_err
);
    state_e      state_q, state_d;
    logic [13:0] biad_q, biad_d, bead_q, bead_d, bwcount_q, bwcount_d;
    logic        bdir_q, bdir_d;
    logic [1:0]  btype_q, btype_d;
    logic        ext_req_q, ext_req_d, ext_we_q, ext_we_d, bsreq_q, bsreq_d;
    logic        irq_q, irq_d, busy_q, busy_d, type_err_q, type_err_d;
    logic        pk_clear, pk_latch, pk_shift, pk_last;
    logic [23:0] pk_word;
    logic [7:0]  pk_byte;
    logic        wr_biad, wr_bead, wr_ctl, wr_cnt, qual_ok;

    assign wr_biad = reg_we && (reg_sel == SEL_BIAD);
    assign wr_bead = reg_we && (reg_sel == SEL_BEAD);
    assign wr_ctl  = reg_we && (reg_sel == SEL_BCTL);
    assign wr_cnt  = reg_we && (reg_sel == SEL_BWCOUNT);
    assign qual_ok = (btype_q == BTYPE_PM24) ? (BPM_cyc && !BDM_cyc) : (BDM_cyc && !BPM_cyc);

    always_comb begin
        state_d    = state_q;
        biad_d     = biad_q;
        bead_d     = bead_q;
        bwcount_d  = bwcount_q;
        bdir_d     = bdir_q;
        btype_d    = btype_q;
        type_err_d = type_err_q;
        irq_d      = 1'b0;
        pk_clear   = 1'b0;
        pk_latch   = 1'b0;
        pk_shift   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wr_biad) biad_d = reg_wd;
                if (wr_bead) bead_d = reg_wd;
                if (wr_ctl) begin
                    bdir_d  = reg_wd[2];
                    btype_d = reg_wd[1:0];
                end
                if (wr_cnt && (reg_wd != 14'd0)) begin
                    state_d  = bdir_q ? ST_STEAL : ST_BYTE;
                    pk_clear = 1'b1;
                end
            end
            ST_BYTE: if (ext_ack) begin
                pk_shift = 1'b1;
                bead_d   = bead_q + 14'd1;
                if (pk_last) begin
                    // A store finishes once its final word is fully unpacked.
                    if (bdir_q && (bwcount_q == 14'd0)) begin
                        state_d = ST_IDLE;
                        irq_d   = 1'b1;
                    end else begin
                        state_d = ST_STEAL;
                    end
                end
            end
            ST_STEAL: if (BM_cyc) begin
                biad_d    = biad_q + 14'd1;
                bwcount_d = bwcount_q - 14'd1;
                if (!qual_ok) type_err_d = 1'b1;
                if (bdir_q) begin
                    pk_latch = 1'b1;
                    state_d  = ST_BYTE;
                end else begin
                    pk_clear = 1'b1;
                    if (bwcount_q == 14'd1) begin
                        state_d = ST_IDLE;
                        irq_d   = 1'b1;
                    end else begin
                        state_d = ST_BYTE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (wr_cnt) begin
            bwcount_d = reg_wd;
            if ((state_q != ST_IDLE) && (reg_wd == 14'd0)) begin
                state_d = ST_IDLE;
                irq_d   = 1'b0;
            end
        end
        if (wr_ctl) type_err_d = 1'b0;
        ext_req_d = (state_d == ST_BYTE);
        ext_we_d  = (state_d == ST_BYTE) && bdir_q;
        bsreq_d   = (state_d == ST_STEAL);
        busy_d    = (state_d != ST_IDLE) || irq_d;
    end

    always_ff @(posedge DSPCLK) begin
        if (T_RST) begin
            state_q    <= ST_IDLE;
            biad_q     <= '0;
            bead_q     <= '0;
            bwcount_q  <= '0;
            bdir_q     <= 1'b0;
            btype_q    <= '0;
            ext_req_q  <= 1'b0;
            ext_we_q   <= 1'b0;
            bsreq_q    <= 1'b0;
            irq_q      <= 1'b0;
            busy_q     <= 1'b0;
            type_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            biad_q     <= biad_d;
            bead_q     <= bead_d;
            bwcount_q  <= bwcount_d;
            bdir_q     <= bdir_d;
            btype_q    <= btype_d;
            ext_req_q  <= ext_req_d;
            ext_we_q   <= ext_we_d;
            bsreq_q    <= bsreq_d;
            irq_q      <= irq_d;
            busy_q     <= busy_d;
            type_err_q <= type_err_d;
        end
    end

    bdma_packer u_packer (
        .clk       (DSPCLK),
        .rst       (T_RST),
        .btype     (btype_q),
        .dir       (bdir_q),
        .clear     (pk_clear),
        .latch     (pk_latch),
        .shift     (pk_shift),
        .byte_in   (ext_rdata),
        .word_in   (core_rdata),
        .word_out  (pk_word),
        .byte_out  (pk_byte),
        .last_byte (pk_last)
    );

    assign BSreqx     = bsreq_q;
    assign BIAD       = biad_q;
    assign core_wdata = pk_word;
    assign ext_req    = ext_req_q;
    assign ext_we     = ext_we_q;
    assign ext_addr   = bead_q;
    assign ext_wdata  = ext_we_q ? pk_byte : 8'h00;
    assign busy       = busy_q;
    assign bdma_irq   = irq_q;
    assign type_err   = type_err_q;

endmodule

// File: tb/tb_bdma_requester.sv
// Bench for bdma_requester: directed and randomized transfers against a
// word/byte-level reference model built from the packing rules.
`timescale 1ns/1ps
module tb_bdma_requester;
    logic        DSPCLK = 1'b0;
    logic        T_RST = 1'b1;
    logic        reg_we = 1'b0;
    logic [1:0]  reg_sel = 2'd0;
    logic [13:0] reg_wd = 14'd0;
    logic [7:0]  ext_rdata = 8'h00;
    logic        ext_ack = 1'b0;
    logic        BM_cyc = 1'b0;
    logic        BPM_cyc = 1'b0;
    logic        BDM_cyc = 1'b0;
    logic [23:0] core_rdata = 24'h0;
    logic        BSreqx, ext_req, ext_we, busy, bdma_irq, type_err;
    logic [13:0] BIAD, ext_addr;
    logic [23:0] core_wdata;
    logic [7:0]  ext_wdata;

    bdma_requester dut (
        .DSPCLK(DSPCLK), .T_RST(T_RST), .reg_we(reg_we), .reg_sel(reg_sel), .reg_wd(reg_wd),
        .ext_rdata(ext_rdata), .ext_ack(ext_ack), .BM_cyc(BM_cyc), .BPM_cyc(BPM_cyc),
        .BDM_cyc(BDM_cyc), .core_rdata(core_rdata), .BSreqx(BSreqx), .BIAD(BIAD),
        .core_wdata(core_wdata), .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr),
        .ext_wdata(ext_wdata), .busy(busy), .bdma_irq(bdma_irq), .type_err(type_err)
    );

    always #5 DSPCLK = ~DSPCLK;

    int vectors = 0;
    int miscompares = 0;
    int last_irq_cycle = 0;

    logic [7:0]  src_b[$];
    logic [23:0] src_w[$];
    logic [37:0] exp_q[$];   // load: {internal address, packed word}
    logic [21:0] exp_b_q[$]; // store: {byte address, byte}
    logic [13:0] exp_a_q[$]; // store: internal address of each read

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge DSPCLK);
        #1;
    endtask

    task automatic reg_write(input logic [1:0] sel, input logic [13:0] wd);
        reg_we = 1'b1; reg_sel = sel; reg_wd = wd;
        tick();
        reg_we = 1'b0;
    endtask

    function automatic int bytes_for(input logic [1:0] bt);
        return (bt == 2'b00) ? 3 : (bt == 2'b01) ? 2 : 1;
    endfunction

    task automatic fill_random(input int nbytes, input int nwords);
        src_b.delete();
        src_w.delete();
        for (int i = 0; i < nbytes; i++) src_b.push_back(8'($urandom));
        for (int i = 0; i < nwords; i++) src_w.push_back(24'($urandom));
    endtask

    task automatic run_xfer(input logic dir, input logic [1:0] bt, input logic [13:0] biad0,
                            input logic [13:0] bead0, input int n, input int ext_min, input int ext_max,
                            input int gnt_min, input int gnt_max, input logic bad_qual);
        int nb, idx, bi, wi, ew, ed, gw, gd, irq_cnt;
        logic done;
        logic [23:0] w;
        logic [7:0] b;
        nb = bytes_for(bt);
        exp_q.delete(); exp_b_q.delete(); exp_a_q.delete();
        idx = 0;
        for (int k = 0; k < n; k++) begin
            if (!dir) begin
                case (bt)
                    2'b00:   w = {src_b[3*k], src_b[3*k+1], src_b[3*k+2]};
                    2'b01:   w = {8'h00, src_b[2*k], src_b[2*k+1]};
                    2'b10:   w = {8'h00, src_b[k], 8'h00};
                    default: w = {16'h0000, src_b[k]};
                endcase
                exp_q.push_back({14'(biad0 + k), w});
            end else begin
                w = src_w[k];
                exp_a_q.push_back(14'(biad0 + k));
                for (int j = 0; j < nb; j++) begin
                    case (bt)
                        2'b10:   b = w[15:8];
                        2'b11:   b = w[7:0];
                        default: b = 8'(w >> (8 * (nb - 1 - j)));
                    endcase
                    exp_b_q.push_back({14'(bead0 + idx), b});
                    idx++;
                end
            end
        end
        reg_write(2'd0, biad0);
        reg_write(2'd1, bead0);
        reg_write(2'd2, {11'd0, dir, bt});
        reg_write(2'd3, 14'(n));
        check("busy_after_start", busy, 1);
        irq_cnt = 0; bi = 0; wi = 0; ew = 0; gw = 0; done = 1'b0;
        ed = $urandom_range(ext_max, ext_min);
        gd = $urandom_range(gnt_max, gnt_min);
        for (int c = 0; c < 4000 && !done; c++) begin
            ext_ack = 1'b0; BM_cyc = 1'b0; BPM_cyc = 1'b0; BDM_cyc = 1'b0;
            if (bdma_irq) begin
                irq_cnt++;
                last_irq_cycle = c;
                check("busy_at_irq", busy, 1);
                done = 1'b1;
            end else begin
                check("busy_during", busy, 1);
                if (ext_req) begin
                    if (ew >= ed) begin
                        ext_ack = 1'b1; ew = 0;
                        ed = $urandom_range(ext_max, ext_min);
                        check("ext_we", ext_we, dir);
                        if (dir) begin
                            check("store_byte_pending", exp_b_q.size() > 0, 1);
                            if (exp_b_q.size() > 0) check("store_byte", {ext_addr, ext_wdata}, exp_b_q.pop_front());
                        end else begin
                            check("load_byte_addr", ext_addr, 14'(bead0 + bi));
                            ext_rdata = (bi < src_b.size()) ? src_b[bi] : 8'h00;
                            bi++;
                        end
                    end else begin
                        ew++;
                    end
                end
                if (BSreqx) begin
                    if (!dir) begin
                        check("load_word_pending", exp_q.size() > 0, 1);
                        if (exp_q.size() > 0) check("load_word_hold", {BIAD, core_wdata}, exp_q[0]);
                    end
                    if (gw >= gd) begin
                        BM_cyc = 1'b1; gw = 0;
                        BPM_cyc = (bt == 2'b00) ^ bad_qual;
                        BDM_cyc = (bt != 2'b00) ^ bad_qual;
                        gd = $urandom_range(gnt_max, gnt_min);
                        if (dir) begin
                            check("store_read_pending", exp_a_q.size() > 0, 1);
                            if (exp_a_q.size() > 0) check("store_biad", BIAD, exp_a_q.pop_front());
                            core_rdata = (wi < src_w.size()) ? src_w[wi] : 24'h0;
                            wi++;
                        end else if (exp_q.size() > 0) begin
                            void'(exp_q.pop_front());
                        end
                    end else begin
                        gw++;
                    end
                end
            end
            tick();
        end
        ext_ack = 1'b0; BM_cyc = 1'b0; BPM_cyc = 1'b0; BDM_cyc = 1'b0;
        check("irq_count", irq_cnt, 1);
        check("irq_pulse_width", bdma_irq, 0);
        check("busy_after_irq", busy, 0);
        check("req_idle", {ext_req, BSreqx}, 0);
        check("final_bead", ext_addr, 14'(bead0 + n * nb));
        check("final_biad", BIAD, 14'(biad0 + n));
        check("left_over", exp_q.size() + exp_b_q.size() + exp_a_q.size(), 0);
        check("type_err", type_err, bad_qual);
    endtask

    initial begin
        int irq_seen;
        // Reset values
        tick(); tick();
        check("rst_outputs", {BSreqx, BIAD, core_wdata, ext_req, ext_we, ext_addr, ext_wdata, busy, bdma_irq, type_err}, 0);
        T_RST = 1'b0;
        tick();

        // Load PM, two words
        src_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        src_w.delete();
        run_xfer(1'b0, 2'b00, 14'h0100, 14'h0000, 2, 0, 0, 0, 0, 1'b0);

        // Store DM16, one word
        src_b.delete();
        src_w = '{24'h00ABCD};
        run_xfer(1'b1, 2'b01, 14'h0040, 14'h0000, 1, 0, 0, 0, 0, 1'b0);

        // 8-bit modes
        src_b = '{8'h5A};
        run_xfer(1'b0, 2'b10, 14'h0020, 14'h0005, 1, 0, 0, 0, 0, 1'b0);
        run_xfer(1'b0, 2'b11, 14'h0021, 14'h0006, 1, 0, 0, 0, 0, 1'b0);

        // Zero-wait DM16 load throughput: 3 cycles per word
        fill_random(4, 0);
        run_xfer(1'b0, 2'b01, 14'h0300, 14'h0100, 2, 0, 0, 0, 0, 1'b0);
        check("dm16_cycles", last_irq_cycle, 6);

        // Delayed ack and grant
        fill_random(6, 2);
        run_xfer(1'b0, 2'b01, 14'h0400, 14'h0200, 3, 2, 2, 4, 4, 1'b0);
        run_xfer(1'b1, 2'b00, 14'h0500, 14'h0210, 2, 2, 2, 4, 4, 1'b0);

        // Address wrap on both sides
        fill_random(2, 0);
        run_xfer(1'b0, 2'b11, 14'h3FFF, 14'h3FFF, 2, 0, 1, 0, 1, 1'b0);

        // Randomized transfers
        for (int r = 0; r < 10; r++) begin
            logic rdir;
            logic [1:0] rbt;
            int rn;
            rdir = 1'($urandom_range(1, 0));
            rbt = 2'($urandom_range(3, 0));
            rn = $urandom_range(4, 1);
            fill_random(rn * 3, rn);
            run_xfer(rdir, rbt, 14'($urandom), 14'($urandom), rn, 0, 3, 0, 3, 1'b0);
        end

        // Wrong PM/DM qualifier, then BCTL write clears it
        fill_random(3, 0);
        run_xfer(1'b0, 2'b00, 14'h0600, 14'h0300, 1, 0, 0, 0, 0, 1'b1);
        reg_write(2'd2, 14'h0000);
        check("type_err_cleared", type_err, 0);

        // Abort mid-word; BIAD write while busy is ignored
        reg_write(2'd0, 14'h0200);
        reg_write(2'd1, 14'h0010);
        reg_write(2'd2, 14'h0001);
        reg_write(2'd3, 14'd3);
        check("abort_req_up", ext_req, 1);
        ext_ack = 1'b1; ext_rdata = 8'hC3;
        tick();
        ext_ack = 1'b0;
        check("abort_midword_req", ext_req, 1);
        reg_write(2'd0, 14'h3333);
        check("busy_biad_ignored", BIAD, 14'h0200);
        reg_write(2'd3, 14'd0);
        check("abort_idle", {ext_req, BSreqx, busy, bdma_irq}, 0);
        check("abort_bead", ext_addr, 14'h0011);
        irq_seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (bdma_irq || ext_req || BSreqx) irq_seen++;
            tick();
        end
        check("abort_quiet", irq_seen, 0);

        // Reset while in STEAL, with a sticky type error pending
        reg_write(2'd0, 14'h0055);
        reg_write(2'd1, 14'h0077);
        reg_write(2'd2, 14'h0003);
        reg_write(2'd3, 14'd2);
        check("rst_seq_req1", ext_req, 1);
        ext_ack = 1'b1; ext_rdata = 8'hA5;
        tick();
        ext_ack = 1'b0;
        check("rst_seq_bsreq1", BSreqx, 1);
        BM_cyc = 1'b1; BPM_cyc = 1'b1; BDM_cyc = 1'b0;
        tick();
        BM_cyc = 1'b0; BPM_cyc = 1'b0;
        check("rst_seq_req2", ext_req, 1);
        check("rst_seq_type_err", type_err, 1);
        ext_ack = 1'b1; ext_rdata = 8'hA5;
        tick();
        ext_ack = 1'b0;
        check("rst_seq_steal", {BSreqx, BIAD, core_wdata}, {1'b1, 14'h0056, 24'h0000A5});
        T_RST = 1'b1;
        tick();
        T_RST = 1'b0;
        check("mid_rst_outputs", {BSreqx, BIAD, core_wdata, ext_req, ext_we, ext_addr, ext_wdata, busy, bdma_irq, type_err}, 0);
        BM_cyc = 1'b1; BDM_cyc = 1'b1;
        tick();
        BM_cyc = 1'b0; BDM_cyc = 1'b0;
        check("stray_grant", {BSreqx, BIAD, busy, bdma_irq}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
